// File: rtl/rx_packet_parser.sv
// Receive-side packet parser: frames cmd, len, payload, sum from a UART byte
// stream, writes the payload to RAM and reports done/error per packet.
module rx_packet_parser #(
    parameter int unsigned CLOCK   = 10_000_000,
    parameter int unsigned BAUD    = 1_000_000,
    parameter int unsigned NUMBER  = 256,
    parameter int unsigned TIMEOUT = 200,
    localparam int unsigned AW     = $clog2(NUMBER)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          rx_error,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] wr_addr,
    output logic          wr_en,
    output logic [7:0]    cmd_rx,
    output logic [AW-1:0] len_rx,
    output logic          pckt_done,
    output logic          pckt_error,
    output logic [1:0]    err_code,
    output logic          busy
);

    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [8:0]  LEN_MAX = 9'(NUMBER - 1);

    localparam logic [1:0] ERR_SUM     = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_BYTE    = 2'd3;

    // Elaboration-time guard on the legal parameter range
    if (NUMBER < 2 || NUMBER > 256 || TIMEOUT < 1 || BAUD == 0 || CLOCK < BAUD) begin : g_bad_params
        $error("rx_packet_parser: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_SUM
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [AW-1:0]     len_q, len_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [7:0]        acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        cmd_rx_q, cmd_rx_d;
    logic [AW-1:0]     len_rx_q, len_rx_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        len_d      = len_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cmd_rx_d   = cmd_rx_q;
        len_rx_d   = len_rx_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;

        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (rx_valid && !rx_error) begin
                cmd_d   = rx_data;
                acc_d   = rx_data;
                state_d = S_LEN;
            end
        end else if (rx_valid) begin
            cnt_d = '0;
            if (rx_error) begin
                error_d    = 1'b1;
                err_code_d = ERR_BYTE;
                state_d    = S_IDLE;
            end else begin
                unique case (state_q)
                    S_LEN: begin
                        if ({1'b0, rx_data} > LEN_MAX) begin
                            error_d    = 1'b1;
                            err_code_d = ERR_LEN;
                            state_d    = S_IDLE;
                        end else begin
                            len_d   = AW'(rx_data);
                            acc_d   = 8'(acc_q + rx_data);
                            idx_d   = '0;
                            state_d = (rx_data == 8'd0) ? S_SUM : S_DATA;
                        end
                    end
                    S_DATA: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q;
                        wr_data_d = rx_data;
                        acc_d     = 8'(acc_q + rx_data);
                        idx_d     = AW'(idx_q + AW'(1));
                        if (idx_q == AW'(len_q - AW'(1))) begin
                            state_d = S_SUM;
                        end
                    end
                    S_SUM: begin
                        state_d = S_IDLE;
                        if (8'(acc_q + rx_data) == 8'hFF) begin
                            done_d   = 1'b1;
                            cmd_rx_d = cmd_q;
                            len_rx_d = len_q;
                        end else begin
                            error_d    = 1'b1;
                            err_code_d = ERR_SUM;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            cnt_d      = '0;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = S_IDLE;
        end else begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cmd_rx_q   <= '0;
            len_rx_q   <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cmd_rx_q   <= cmd_rx_d;
            len_rx_q   <= len_rx_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cmd_rx     = cmd_rx_q;
    assign len_rx     = len_rx_q;
    assign pckt_done  = done_q;
    assign pckt_error = error_q;
    assign err_code   = err_code_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Self-checking bench for rx_packet_parser: directed cases plus randomized
// packets scored against a packet-level reference model.
module tb_rx_packet_parser;

    localparam int unsigned NUMBER  = 16;
    localparam int unsigned TIMEOUT = 200;
    localparam int unsigned AW      = $clog2(NUMBER);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx_valid = 1'b0;
    logic          rx_error = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic [7:0]    wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic [7:0]    cmd_rx;
    logic [AW-1:0] len_rx;
    logic          pckt_done;
    logic          pckt_error;
    logic [1:0]    err_code;
    logic          busy;

    always #5 clk = ~clk;

    rx_packet_parser #(
        .CLOCK(10_000_000), .BAUD(1_000_000), .NUMBER(NUMBER), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en), .cmd_rx(cmd_rx), .len_rx(len_rx),
        .pckt_done(pckt_done), .pckt_error(pckt_error), .err_code(err_code), .busy(busy)
    );

    typedef struct packed {
        logic          is_err;
        logic [1:0]    code;
        logic [7:0]    cmd;
        logic [AW-1:0] len;
    } ev_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    ev_t        ev_log[$], exp_ev[$];
    wr_t        wr_log[$], exp_wr[$];
    logic [7:0] pkt[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0]    mdl_cmd;
    logic [AW-1:0] mdl_len;
    logic [1:0]    mdl_code;

    // Record every RAM write and every done/error pulse while out of reset
    always @(negedge clk) begin
        if (reset) begin
            if (wr_en) wr_log.push_back({wr_addr, wr_data});
            if (pckt_done || pckt_error) begin
                ev_log.push_back({pckt_error, err_code, cmd_rx, len_rx});
                checks++;
                if (pckt_done && pckt_error) begin
                    errors++;
                    $display("FAIL pulse_exclusive: done=%0b error=%0b, required not both", pckt_done, pckt_error);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_logs();
        ev_log.delete(); wr_log.delete(); exp_ev.delete(); exp_wr.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mdl_cmd = 8'h00; mdl_len = '0; mdl_code = 2'd0;
        clear_logs();
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic e, input int gap);
        rx_valid = 1'b1; rx_data = b; rx_error = e;
        @(negedge clk);
        rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send(input int err_idx, input int nsend, input int max_gap);
        for (int i = 0; i < nsend; i++)
            drive_byte(pkt[i], i == err_idx, int'($urandom_range(max_gap, 0)));
    endtask

    // Random packet: len sometimes illegal, checksum sometimes corrupted
    task automatic build_pkt(input bit allow_bad);
        int len;
        logic [7:0] s;
        pkt.delete();
        pkt.push_back(8'($urandom));
        len = (allow_bad && $urandom_range(7, 0) == 0) ? int'($urandom_range(255, NUMBER))
                                                      : int'($urandom_range(NUMBER - 1, 0));
        pkt.push_back(8'(len));
        if (len <= NUMBER - 1) begin
            for (int k = 0; k < len; k++) pkt.push_back(8'($urandom));
            s = 8'h00;
            foreach (pkt[i]) s = 8'(s + pkt[i]);
            s = ~s;
            if (allow_bad && $urandom_range(3, 0) == 0) s = 8'(s + 8'($urandom_range(255, 1)));
            pkt.push_back(s);
        end
    endtask

    // Reference: expected writes/outcome of one packet from the framing rules
    task automatic model_pkt(input int err_idx, output int nsend);
        int len;
        logic [7:0] tot;
        len = int'(pkt[1]);
        if (err_idx == 1) begin
            mdl_code = 2'd3; exp_ev.push_back({1'b1, 2'd3, mdl_cmd, mdl_len}); nsend = 2; return;
        end
        if (len > NUMBER - 1) begin
            mdl_code = 2'd1; exp_ev.push_back({1'b1, 2'd1, mdl_cmd, mdl_len}); nsend = 2; return;
        end
        for (int k = 0; k < len; k++) begin
            if (err_idx == 2 + k) begin
                mdl_code = 2'd3; exp_ev.push_back({1'b1, 2'd3, mdl_cmd, mdl_len}); nsend = 3 + k; return;
            end
            exp_wr.push_back({AW'(k), pkt[2 + k]});
        end
        nsend = pkt.size();
        if (err_idx == 2 + len) begin
            mdl_code = 2'd3; exp_ev.push_back({1'b1, 2'd3, mdl_cmd, mdl_len}); return;
        end
        tot = 8'h00;
        foreach (pkt[i]) tot = 8'(tot + pkt[i]);
        if (tot == 8'hFF) begin
            mdl_cmd = pkt[0]; mdl_len = AW'(len);
            exp_ev.push_back({1'b0, mdl_code, mdl_cmd, mdl_len});
        end else begin
            mdl_code = 2'd0; exp_ev.push_back({1'b1, 2'd0, mdl_cmd, mdl_len});
        end
    endtask

    task automatic test_reset();
        logic [34:0] outs;
        repeat (2) @(negedge clk);
        outs = {wr_data, wr_addr, wr_en, cmd_rx, len_rx, pckt_done, pckt_error, err_code, busy};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h, required 0", outs); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        outs = {wr_data, wr_addr, wr_en, cmd_rx, len_rx, pckt_done, pckt_error, err_code, busy};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL post_reset_idle: got %h, required 0", outs); end
    endtask

    task automatic test_directed();
        clear_logs();
        pkt = '{8'h12, 8'h03, 8'h01, 8'h02, 8'h03, 8'hE4};
        send(-1, pkt.size(), 1); repeat (3) @(negedge clk);
        checks++;
        if (wr_log.size() != 3 || wr_log[0] !== {4'd0, 8'h01} || wr_log[1] !== {4'd1, 8'h02} || wr_log[2] !== {4'd2, 8'h03}) begin
            errors++; $display("FAIL good_pkt_writes: got %0d writes, required 0:01 1:02 2:03", wr_log.size());
        end
        checks++;
        if (ev_log.size() != 1 || ev_log[0] !== {1'b0, 2'd0, 8'h12, 4'd3}) begin
            errors++; $display("FAIL good_pkt_done: got %0d events first=%h, required done cmd 12 len 3", ev_log.size(), ev_log[0]);
        end

        clear_logs();
        pkt = '{8'hA5, 8'h00, 8'h5A};
        send(-1, pkt.size(), 2); repeat (3) @(negedge clk);
        checks++;
        if (wr_log.size() != 0 || ev_log.size() != 1 || ev_log[0] !== {1'b0, 2'd0, 8'hA5, 4'd0}) begin
            errors++; $display("FAIL zero_len: got %0d writes %0d events first=%h, required 0 writes done A5/0", wr_log.size(), ev_log.size(), ev_log[0]);
        end

        clear_logs();
        pkt = '{8'h12, 8'h03, 8'h01, 8'h02, 8'h03, 8'hE5};
        send(-1, pkt.size(), 0); repeat (3) @(negedge clk);
        checks++;
        if (wr_log.size() != 3 || ev_log.size() != 1 || ev_log[0] !== {1'b1, 2'd0, 8'hA5, 4'd0}) begin
            errors++; $display("FAIL bad_sum: got %0d writes %0d events first=%h, required 3 writes error code 0 A5/0", wr_log.size(), ev_log.size(), ev_log[0]);
        end

        clear_logs();
        pkt = '{8'h01, 8'h10};
        send(-1, 2, 0);
        pkt = '{8'h01, 8'h01, 8'h07, 8'hF6};
        send(-1, pkt.size(), 0); repeat (3) @(negedge clk);
        checks++;
        if (ev_log.size() != 2 || ev_log[0] !== {1'b1, 2'd1, 8'hA5, 4'd0} || ev_log[1] !== {1'b0, 2'd1, 8'h01, 4'd1}) begin
            errors++; $display("FAIL len_error_recover: got %0d events first=%h, required len error then done 01/1", ev_log.size(), ev_log[0]);
        end
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== {4'd0, 8'h07}) begin
            errors++; $display("FAIL len_error_writes: got %0d writes, required one write 0:07", wr_log.size());
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        drive_byte(8'h33, 1'b0, 0); drive_byte(8'h02, 1'b0, 0); drive_byte(8'hAA, 1'b0, 0);
        repeat (TIMEOUT - 1) @(negedge clk);
        checks++;
        if (pckt_error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early: error=%0b busy=%0b at cycle %0d, required 0/1", pckt_error, busy, TIMEOUT - 1);
        end
        @(negedge clk);
        checks++;
        if (pckt_error !== 1'b1 || err_code !== 2'd2 || cmd_rx !== 8'h01) begin
            errors++; $display("FAIL timeout_fire: error=%0b code=%0d cmd_rx=%h, required 1/2/01", pckt_error, err_code, cmd_rx);
        end
        repeat (2) @(negedge clk);
        clear_logs();
        drive_byte(8'h5A, 1'b0, 0); drive_byte(8'h02, 1'b0, 0); drive_byte(8'hAA, 1'b0, TIMEOUT - 1);
        drive_byte(8'hBB, 1'b0, 0);
        checks++;
        if (ev_log.size() != 0 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_byte_wins: got %0d events busy=%0b, required 0 events busy 1", ev_log.size(), busy);
        end
        drive_byte(8'h3E, 1'b0, 0); repeat (3) @(negedge clk);
        checks++;
        if (ev_log.size() != 1 || ev_log[0] !== {1'b0, 2'd2, 8'h5A, 4'd2}) begin
            errors++; $display("FAIL timeout_then_done: got %0d events first=%h, required done 5A/2", ev_log.size(), ev_log[0]);
        end
    endtask

    task automatic test_rx_error_and_midreset();
        logic [34:0] outs;
        clear_logs();
        pkt = '{8'hC3, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        send(3, 4, 1); repeat (3) @(negedge clk);
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== {4'd0, 8'h11} || ev_log.size() != 1 || ev_log[0] !== {1'b1, 2'd3, 8'h5A, 4'd2}) begin
            errors++; $display("FAIL rx_error_abort: got %0d writes %0d events first=%h, required 1 write error code 3", wr_log.size(), ev_log.size(), ev_log[0]);
        end
        clear_logs();
        drive_byte(8'h77, 1'b0, 0); drive_byte(8'h03, 1'b0, 0); drive_byte(8'h44, 1'b0, 1);
        reset = 1'b0;
        #1;
        outs = {wr_data, wr_addr, wr_en, cmd_rx, len_rx, pckt_done, pckt_error, err_code, busy};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL midreset_outputs: got %h, required 0", outs); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (TIMEOUT + 5) @(negedge clk);
        checks++;
        if (ev_log.size() != 0) begin errors++; $display("FAIL midreset_no_pulse: got %0d events, required 0", ev_log.size()); end
        pkt = '{8'h12, 8'h03, 8'h01, 8'h02, 8'h03, 8'hE4};
        send(-1, pkt.size(), 0); repeat (3) @(negedge clk);
        checks++;
        if (ev_log.size() != 1 || ev_log[0] !== {1'b0, 2'd0, 8'h12, 4'd3} || wr_log.size() != 4) begin
            errors++; $display("FAIL midreset_recover: got %0d events first=%h %0d writes, required done 12/3 and 4 writes", ev_log.size(), ev_log[0], wr_log.size());
        end
    endtask

    task automatic test_random();
        int err_idx, nsend;
        apply_reset();
        for (int p = 0; p < 25; p++) begin
            build_pkt(1'b1);
            err_idx = ($urandom_range(7, 0) == 0) ? int'($urandom_range(pkt.size() - 1, 1)) : -1;
            model_pkt(err_idx, nsend);
            send(err_idx, nsend, 3);
            repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_log.size() != exp_wr.size()) begin errors++; $display("FAIL rand_write_count: got %0d, required %0d", wr_log.size(), exp_wr.size()); end
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
            checks++;
            if (wr_log[i] !== exp_wr[i]) begin errors++; $display("FAIL rand_write[%0d]: got %h, required %h", i, wr_log[i], exp_wr[i]); end
        end
        checks++;
        if (ev_log.size() != exp_ev.size()) begin errors++; $display("FAIL rand_event_count: got %0d, required %0d", ev_log.size(), exp_ev.size()); end
        for (int i = 0; i < ev_log.size() && i < exp_ev.size(); i++) begin
            checks++;
            if (ev_log[i] !== exp_ev[i]) begin errors++; $display("FAIL rand_event[%0d]: got %h, required %h", i, ev_log[i], exp_ev[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int nsend;
        clear_logs();
        @(negedge clk);
        for (int p = 0; p < 8; p++) begin
            build_pkt(p[0]);
            model_pkt(-1, nsend);
            send(-1, nsend, 0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_log.size() != exp_wr.size()) begin errors++; $display("FAIL b2b_write_count: got %0d, required %0d", wr_log.size(), exp_wr.size()); end
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
            checks++;
            if (wr_log[i] !== exp_wr[i]) begin errors++; $display("FAIL b2b_write[%0d]: got %h, required %h", i, wr_log[i], exp_wr[i]); end
        end
        checks++;
        if (ev_log.size() != exp_ev.size()) begin errors++; $display("FAIL b2b_event_count: got %0d, required %0d", ev_log.size(), exp_ev.size()); end
        for (int i = 0; i < ev_log.size() && i < exp_ev.size(); i++) begin
            checks++;
            if (ev_log[i] !== exp_ev[i]) begin errors++; $display("FAIL b2b_event[%0d]: got %h, required %h", i, ev_log[i], exp_ev[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_rx_error_and_midreset();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
